// File: rtl/uart_tx_mmio_if.sv
// Request side of the CPU memory bus as seen by a memory-mapped responder.
// The shared data lines are a tristate net and are carried as a separate
// inout port on the responder.
interface uart_tx_mmio_if;
  logic [7:0] addr;
  logic       mw;
  logic       mr;

  modport master (output addr, output mw, output mr);
  modport slave  (input addr, input mw, input mr);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Window: BASE+0 TXDATA (wo), BASE+1 STATUS (ro), BASE+2 BAUDDIV (rw), BASE+3 zero.
//
// state   | meaning
// --------+------------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for one bit period
// S_DATA  | data bits, LSB first, bit index in idx_q
// S_STOP  | stop bit (high); chains straight into S_START if FIFO non-empty
module uart_tx_mmio #(
  parameter logic [7:0] BASE_ADDR   = 8'h80,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] DEFAULT_DIV = 8'd103
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_mmio_if.slave      bus,
  inout  wire  [7:0]         data,
  output logic               tx,
  output logic               busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      div_q;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            tx_q, tx_d;

  logic       sel, wr_en, rd_en, wr_txdata, wr_div, rd_status;
  logic       full, empty, push, pop, bit_end;
  logic [3:0] count_ext;
  logic [2:0] count_sat;
  logic [7:0] status, rdata;

  assign sel       = (bus.addr[7:2] == BASE_ADDR[7:2]);
  assign wr_en     = sel & bus.mw;
  assign rd_en     = sel & bus.mr;
  assign wr_txdata = wr_en & (bus.addr[1:0] == 2'd0);
  assign wr_div    = wr_en & (bus.addr[1:0] == 2'd2);
  assign rd_status = rd_en & (bus.addr[1:0] == 2'd1);

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign bit_end = (cnt_q >= div_q);

  // A byte offered while full is still taken if a pop frees a slot this cycle.
  assign push = wr_txdata & (~full | pop);

  assign count_ext = 4'(count_q);
  assign count_sat = (count_ext > 4'd7) ? 3'd7 : count_ext[2:0];
  assign status    = {1'b0, ovf_q, count_sat, empty, full, (state_q != S_IDLE)};

  // Combinational read mux for the register window.
  always_comb begin
    rdata = 8'h00;
    case (bus.addr[1:0])
      2'd1:    rdata = status;
      2'd2:    rdata = div_q;
      default: rdata = 8'h00;
    endcase
  end

  assign data = rd_en ? rdata : 8'bz;
  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE) | ~empty;

  // Serialiser next state; the bit counter restarts on every bit boundary.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 8'd1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO occupancy and sticky overflow; a set beats a same-cycle clear.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (rd_status) ovf_d = 1'b0;
    if (wr_txdata & full & ~pop) ovf_d = 1'b1;
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shift_q  <= 8'h00;
      idx_q    <= 3'd0;
      cnt_q    <= 8'd0;
      tx_q     <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_div) div_q    <= data;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

endmodule
